// File: rtl/avalon_bus_monitor.sv
// Passive Avalon-MM bus monitor that runs while the CPU is active.
// It counts bus traffic, flags protocol errors and captures the CPU result at the end of a run.
module avalon_bus_monitor #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_WAIT       = 16,
  parameter int BYTE_SWAP      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  input  logic [DATA_W-1:0]   register_v0,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  input  logic [DATA_W/8-1:0] byteenable,
  output logic [1:0]          state,
  output logic                done,
  output logic                timeout,
  output logic [DATA_W-1:0]   result,
  output logic [31:0]         cycle_count,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count,
  output logic [31:0]         stall_count,
  output logic [DATA_W-1:0]   last_readdata,
  output logic [4:0]          err_flags,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] WAIT_LIM    = 32'(MAX_WAIT + 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [1:0]        state_q, state_d;
  logic              done_q, done_d, timeout_q, timeout_d;
  logic [DATA_W-1:0] result_q, result_d, last_readdata_q, last_readdata_d;
  logic [31:0]       cycle_count_q, cycle_count_d, read_count_q, read_count_d;
  logic [31:0]       write_count_q, write_count_d, stall_count_q, stall_count_d;
  logic [4:0]        err_flags_q, err_flags_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  // Snapshot of the previous bus cycle, used to detect a request changing while stalled.
  logic              prev_stall_q, prev_stall_d, prev_read_q, prev_read_d;
  logic              prev_write_q, prev_write_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic [BE_W-1:0]   prev_be_q, prev_be_d;
  logic [DATA_W-1:0] prev_wdata_q, prev_wdata_d;
  logic [31:0]       wait_cnt_q, wait_cnt_d;

  logic              run, req;
  logic [4:0]        new_err;
  logic [DATA_W-1:0] swapped, capture;

  always_comb begin
    swapped = '0;
    for (int i = 0; i < BE_W; i++) begin
      swapped[8*i +: 8] = readdata[8*(BE_W-1-i) +: 8];
    end
    capture = (BYTE_SWAP != 0) ? swapped : readdata;
  end

  always_comb begin
    state_d          = state_q;
    done_d           = done_q;
    timeout_d        = timeout_q;
    result_d         = result_q;
    cycle_count_d    = cycle_count_q;
    read_count_d     = read_count_q;
    write_count_d    = write_count_q;
    stall_count_d    = stall_count_q;
    last_readdata_d  = last_readdata_q;
    err_flags_d      = err_flags_q;
    first_err_addr_d = first_err_addr_q;
    wait_cnt_d       = '0;
    new_err          = '0;
    run              = (state_q == ST_RUN);
    req              = read | write;

    prev_stall_d = run & req & waitrequest;
    prev_read_d  = read;
    prev_write_d = write;
    prev_addr_d  = address;
    prev_be_d    = byteenable;
    prev_wdata_d = writedata;

    if (run) begin
      if (req && !waitrequest) begin
        if (read) begin
          read_count_d    = sat_inc(read_count_q);
          last_readdata_d = capture;
        end
        if (write) write_count_d = sat_inc(write_count_q);
      end
      if (req && waitrequest) begin
        stall_count_d = sat_inc(stall_count_q);
        wait_cnt_d    = sat_inc(wait_cnt_q);
        new_err[2]    = (wait_cnt_d == WAIT_LIM);
      end
      new_err[0] = read & write;
      new_err[3] = req && (byteenable == '0);
      new_err[4] = req && (address[1:0] != 2'b00);
      new_err[1] = prev_stall_q && ((read != prev_read_q) || (write != prev_write_q) ||
                   (address != prev_addr_q) || (byteenable != prev_be_q) ||
                   (write && (writedata != prev_wdata_q)));
      if ((err_flags_q == '0) && (new_err != '0)) first_err_addr_d = address;
      err_flags_d   = err_flags_q | new_err;
      cycle_count_d = sat_inc(cycle_count_q);
    end

    case (state_q)
      ST_IDLE: if (active) state_d = ST_RUN;
      ST_RUN: begin
        // Falling active takes priority over reaching the timeout limit.
        if (!active) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = register_v0;
        end else if (cycle_count_d >= TIMEOUT_LIM) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          result_d  = register_v0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      done_q           <= 1'b0;
      timeout_q        <= 1'b0;
      result_q         <= '0;
      cycle_count_q    <= '0;
      read_count_q     <= '0;
      write_count_q    <= '0;
      stall_count_q    <= '0;
      last_readdata_q  <= '0;
      err_flags_q      <= '0;
      first_err_addr_q <= '0;
      prev_stall_q     <= 1'b0;
      prev_read_q      <= 1'b0;
      prev_write_q     <= 1'b0;
      prev_addr_q      <= '0;
      prev_be_q        <= '0;
      prev_wdata_q     <= '0;
      wait_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      done_q           <= done_d;
      timeout_q        <= timeout_d;
      result_q         <= result_d;
      cycle_count_q    <= cycle_count_d;
      read_count_q     <= read_count_d;
      write_count_q    <= write_count_d;
      stall_count_q    <= stall_count_d;
      last_readdata_q  <= last_readdata_d;
      err_flags_q      <= err_flags_d;
      first_err_addr_q <= first_err_addr_d;
      prev_stall_q     <= prev_stall_d;
      prev_read_q      <= prev_read_d;
      prev_write_q     <= prev_write_d;
      prev_addr_q      <= prev_addr_d;
      prev_be_q        <= prev_be_d;
      prev_wdata_q     <= prev_wdata_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

  assign state          = state_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign result         = result_q;
  assign cycle_count    = cycle_count_q;
  assign read_count     = read_count_q;
  assign write_count    = write_count_q;
  assign stall_count    = stall_count_q;
  assign last_readdata  = last_readdata_q;
  assign err_flags      = err_flags_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_avalon_bus_monitor.sv
// Directed bench for avalon_bus_monitor: a per-cycle behavioural model checked against every
// output after each clock, plus literal expectations for the headline scenarios.
module tb_avalon_bus_monitor;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 10;
  localparam int MAXW   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              active = 1'b0;
  logic [DATA_W-1:0] register_v0 = '0;
  logic [ADDR_W-1:0] address = '0;
  logic              read = 1'b0, write = 1'b0, waitrequest = 1'b0;
  logic [DATA_W-1:0] writedata = '0, readdata = '0;
  logic [3:0]        byteenable = '0;
  logic [1:0]        state;
  logic              done, timeout;
  logic [DATA_W-1:0] result, last_readdata;
  logic [31:0]       cycle_count, read_count, write_count, stall_count;
  logic [4:0]        err_flags;
  logic [ADDR_W-1:0] first_err_addr;

  avalon_bus_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO),
                       .MAX_WAIT(MAXW), .BYTE_SWAP(1)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .readdata(readdata), .byteenable(byteenable),
    .state(state), .done(done), .timeout(timeout), .result(result),
    .cycle_count(cycle_count), .read_count(read_count), .write_count(write_count),
    .stall_count(stall_count), .last_readdata(last_readdata), .err_flags(err_flags),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: phase of the run, plain counters and a snapshot of last bus cycle.
  int          m_phase;  // 0 idle, 1 running, 2 finished, 3 timed out
  bit          m_done, m_timeout;
  logic [31:0] m_result, m_last;
  longint      m_cyc, m_rd, m_wr, m_stall;
  logic [4:0]  m_err;
  logic [31:0] m_first;
  bit          h_stalled;
  bit          h_rd, h_wr;
  logic [31:0] h_addr, h_wd;
  logic [3:0]  h_be;
  int          m_wait_run;

  function automatic longint bump(input longint v);
    return (v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  task automatic model_step();
    bit         req;
    logic [4:0] found;
    if (reset) begin
      m_phase = 0; m_done = 0; m_timeout = 0; m_result = 0; m_last = 0;
      m_cyc = 0; m_rd = 0; m_wr = 0; m_stall = 0; m_err = 0; m_first = 0;
      h_stalled = 0; m_wait_run = 0;
      return;
    end
    req = read || write;
    found = 0;
    if (m_phase == 1) begin
      if (req && !waitrequest && read)  begin m_rd = bump(m_rd); m_last = {<<8{readdata}}; end
      if (req && !waitrequest && write) m_wr = bump(m_wr);
      if (req && waitrequest) m_stall = bump(m_stall);
      if (read && write) found[0] = 1;
      if (req && byteenable == 0) found[3] = 1;
      if (req && address[1:0] != 0) found[4] = 1;
      if (h_stalled && (read != h_rd || write != h_wr || address != h_addr ||
                        byteenable != h_be || (write && writedata != h_wd))) found[1] = 1;
      if (req && waitrequest) begin
        m_wait_run++;
        if (m_wait_run == MAXW + 1) found[2] = 1;
      end else m_wait_run = 0;
      if (m_err == 0 && found != 0) m_first = address;
      m_err = m_err | found;
      m_cyc = bump(m_cyc);
      if (!active) begin
        m_phase = 2; m_done = 1; m_result = register_v0;
      end else if (m_cyc >= TMO) begin
        m_phase = 3; m_timeout = 1; m_result = register_v0;
      end
      h_stalled = req && waitrequest;
    end else begin
      m_wait_run = 0;
      h_stalled = 0;
      if (m_phase == 0 && active) m_phase = 1;
    end
    h_rd = read; h_wr = write; h_addr = address; h_be = byteenable; h_wd = writedata;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state", 64'(state), 64'(m_phase));
    chk("done", 64'(done), 64'(m_done));
    chk("timeout", 64'(timeout), 64'(m_timeout));
    chk("result", 64'(result), 64'(m_result));
    chk("cycle_count", 64'(cycle_count), m_cyc);
    chk("read_count", 64'(read_count), m_rd);
    chk("write_count", 64'(write_count), m_wr);
    chk("stall_count", 64'(stall_count), m_stall);
    chk("last_readdata", 64'(last_readdata), 64'(m_last));
    chk("err_flags", 64'(err_flags), 64'(m_err));
    chk("first_err_addr", 64'(first_err_addr), 64'(m_first));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic bus(input bit rd, input bit wr, input bit wq, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rdat);
    read = rd; write = wr; waitrequest = wq; address = a;
    byteenable = be; writedata = wd; readdata = rdat;
  endtask

  task automatic bus_idle();
    bus(0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1; active = 0; register_v0 = 0; bus_idle();
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    // Normal run ending on active falling.
    do_reset();
    chk("rst_state", 64'(state), 0);
    chk("rst_cycle_count", 64'(cycle_count), 0);
    active = 1; tick();
    chk("s1_enter_run", 64'(state), 1);
    repeat (5) tick();
    active = 0; register_v0 = 32'h0000_00AB; tick();
    chk("s1_state", 64'(state), 2);
    chk("s1_done", 64'(done), 1);
    chk("s1_result", 64'(result), 64'h00AB);
    chk("s1_cycle_count", 64'(cycle_count), 6);
    active = 1; bus(1, 0, 0, 32'h100, 4'hF, 0, 32'h1234_5678); tick(); tick();
    chk("s1_done_holds", 64'(state), 2);
    chk("s1_ignored_read", 64'(read_count), 0);
    bus_idle();

    // Timeout after 10 RUN cycles.
    do_reset();
    register_v0 = 32'h5A5A; active = 1; tick();
    repeat (9) tick();
    chk("s2_pre_state", 64'(state), 1);
    tick();
    chk("s2_state", 64'(state), 3);
    chk("s2_timeout", 64'(timeout), 1);
    chk("s2_done", 64'(done), 0);
    chk("s2_cycle_count", 64'(cycle_count), 10);
    chk("s2_result", 64'(result), 64'h5A5A);
    repeat (2) tick();
    chk("s2_hold_count", 64'(cycle_count), 10);

    // Active falls on the limit cycle: done wins.
    do_reset();
    active = 1; tick();
    repeat (9) tick();
    active = 0; register_v0 = 32'h77; tick();
    chk("s3_state", 64'(state), 2);
    chk("s3_timeout", 64'(timeout), 0);
    chk("s3_cycle_count", 64'(cycle_count), 10);

    // Stalled read with byte swap.
    do_reset();
    active = 1; tick();
    bus(1, 0, 1, 32'h100, 4'hF, 0, 32'h0); tick(); tick();
    bus(1, 0, 0, 32'h100, 4'hF, 0, 32'h1122_3344); tick();
    bus_idle(); tick();
    chk("s4_stall_count", 64'(stall_count), 2);
    chk("s4_read_count", 64'(read_count), 1);
    chk("s4_last_readdata", 64'(last_readdata), 64'h4433_2211);
    chk("s4_err_flags", 64'(err_flags), 0);

    // Address change during stall, then a misaligned access.
    do_reset();
    active = 1; tick();
    bus(1, 0, 1, 32'h100, 4'hF, 0, 0); tick();
    bus(1, 0, 1, 32'h104, 4'hF, 0, 0); tick();
    chk("s5_err_change", 64'(err_flags), 64'b00010);
    chk("s5_first_addr", 64'(first_err_addr), 64'h104);
    bus(1, 0, 0, 32'h104, 4'hF, 0, 32'hCAFE_0001); tick();
    bus_idle(); tick();
    bus(1, 0, 0, 32'h102, 4'hF, 0, 32'h0); tick();
    bus_idle(); tick();
    chk("s5_err_misalign", 64'(err_flags), 64'b10010);
    chk("s5_first_kept", 64'(first_err_addr), 64'h104);

    // Read and write together with zero byteenable.
    do_reset();
    active = 1; tick();
    bus(1, 1, 0, 32'h200, 4'h0, 32'h9, 32'h0); tick();
    bus_idle();
    chk("s6_err_flags", 64'(err_flags), 64'b01001);
    chk("s6_first_addr", 64'(first_err_addr), 64'h200);
    tick();

    // Waitrequest held longer than MAX_WAIT cycles.
    do_reset();
    active = 1; tick();
    bus(0, 1, 1, 32'h40, 4'hF, 32'h1234, 0); repeat (MAXW) tick();
    chk("s7_err_at_max", 64'(err_flags), 0);
    tick();
    chk("s7_err_over_max", 64'(err_flags), 64'b00100);
    chk("s7_first_addr", 64'(first_err_addr), 64'h40);
    bus(0, 1, 0, 32'h40, 4'hF, 32'h1234, 0); tick();
    chk("s7_write_count", 64'(write_count), 1);
    bus_idle(); tick();

    // Writedata changes while a write is stalled.
    do_reset();
    active = 1; tick();
    bus(0, 1, 1, 32'h80, 4'hF, 32'h1, 0); tick();
    bus(0, 1, 1, 32'h80, 4'hF, 32'h2, 0); tick();
    chk("s8_err_wdata", 64'(err_flags), 64'b00010);
    chk("s8_first_addr", 64'(first_err_addr), 64'h80);
    bus_idle(); tick();

    // Reset in the middle of a stall.
    do_reset();
    active = 1; tick();
    bus(1, 0, 1, 32'h100, 4'hF, 0, 0); tick(); tick();
    reset = 1; tick();
    chk("s9_state", 64'(state), 0);
    chk("s9_stall_count", 64'(stall_count), 0);
    chk("s9_cycle_count", 64'(cycle_count), 0);
    reset = 0; bus_idle(); active = 0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
